serial_fifo_iface: RTL and testbench
====================================

# serial_fifo_iface

Parametrised UART front end for the command path: receives bytes on `rx_i` into an RX FIFO and transmits bytes from a TX FIFO on `tx_o`. The command-side `cmdfifo_*` handshake is unchanged from the current serial interface, so the register/command decoder attaches without modification. New in this generation: a generic bit period, buffering in both directions, mid-bit sampling with start-glitch rejection, and sticky overflow/framing error flags.

## Interface
- `CLK_DIV`, default 868, clk_i cycles per bit (e.g. 100 MHz / 115200); minimum 4.
- `RX_AW`, default 4, log2 of RX FIFO depth (16 entries).
- `TX_AW`, default 4, log2 of TX FIFO depth (16 entries).

Ports:
- `clk_i` in 1: single clock for the whole block.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `rx_i` in 1: serial input, asynchronous to clk_i.
- `tx_o` out 1: serial output, idle high.
- `cmdfifo_rxf` out 1: RX FIFO non-empty.
- `cmdfifo_txe` out 1: TX FIFO not full.
- `cmdfifo_rd` in 1: pop RX FIFO head.
- `cmdfifo_wr` in 1: push `cmdfifo_dout` into TX FIFO.
- `cmdfifo_din` out 8: RX FIFO head (first-word-fall-through).
- `cmdfifo_dout` in 8: byte to transmit.
- `tx_busy_o` out 1: TX FIFO non-empty or TX FSM not IDLE.
- `err_clr_i` in 1: clears all sticky error flags.
- `rx_ovf_o` out 1: sticky; byte dropped because RX FIFO was full.
- `frame_err_o` out 1: sticky; stop bit sampled low.

## Operation
- Frame format: 1 start bit, 8 data bits LSB first, [parity], 1 stop bit.
- RX input path: 2-flop synchronizer, reset value 1.
- RX FSM states:
  - IDLE: a synchronized falling edge moves the FSM to START.
  - START: waits CLK_DIV/2 cycles (integer divide), then samples. High means a glitch: return to IDLE, nothing pushed. Low moves to DATA.
  - DATA: samples every CLK_DIV cycles, 8 bits; then goes to STOP (or PARITY).
  - STOP: samples after CLK_DIV cycles. High: push the byte. If the FIFO is full, drop the byte and set `rx_ovf_o`. Low: discard the byte, set `frame_err_o`, go to BREAK.
  - BREAK: waits for the synchronized line to be high, then goes to IDLE.
- TX FSM states: IDLE, START, DATA, STOP (PARITY).
  - IDLE with the FIFO non-empty: pop the head into the shift register and go to START.
  - Each state holds `tx_o` for exactly CLK_DIV cycles.
  - From STOP: return to IDLE. If the FIFO is non-empty, the next start bit follows directly, with no extra idle bits.
- FIFOs: synchronous, with pointers one bit wider than the address for full/empty detection; wrap-around is natural binary.
  - Write when full is ignored; read when empty is ignored.
  - Simultaneous push and pop is legal in any state: the count is unchanged. When empty, the pop is ignored and the push proceeds.
- `err_clr_i`: clears both sticky flags. If clear and set happen in the same cycle, set wins.
- Reset mid-frame: both FSMs are forced to IDLE and both FIFOs are emptied. No partial byte is delivered.

## Timing
- Reset values:
  - `tx_o`=1, `cmdfifo_rxf`=0, `cmdfifo_txe`=1, `cmdfifo_din`=0.
  - `tx_busy_o`=0, `rx_ovf_o`=0, `frame_err_o`=0.
- TX latency: `cmdfifo_wr` sampled at edge N with TX idle and FIFO empty. `tx_o` goes low after edge N+2.
- Frame length: 10·CLK_DIV cycles; 11·CLK_DIV with parity.
- RX latency: the byte is written at the stop-sample edge. `cmdfifo_rxf` and `cmdfifo_din` are valid after that edge.
- `cmdfifo_rd` at edge N: `cmdfifo_din` shows the next entry after edge N. `cmdfifo_rxf` falls after edge N if the FIFO became empty.
- `cmdfifo_txe` falls in the cycle after the push that fills the FIFO.
- RX tolerates ±2 % baud mismatch at the default CLK_DIV.

## Configuration
- `SERIAL_PARITY_EN` defined:
  - TX inserts an even-parity bit between D7 and stop.
  - RX samples the parity bit in the PARITY state.
  - A mismatch sets the sticky output `parity_err_o` and discards the byte.
  - `parity_err_o` is cleared by `err_clr_i`.
- `SERIAL_PARITY_EN` undefined: 8N1 only. No PARITY states and no `parity_err_o` port.

## Test plan
All scenarios use CLK_DIV=16, RX_AW=TX_AW=2.
- Reset, then write 0xA5 → `tx_o` low after edge 2 post-write. Bits 1,0,1,0,0,1,0,1, then stop, each held 16 cycles. `tx_busy_o` low 160 cycles after the start bit begins.
- Drive 0x3C on `rx_i` → `cmdfifo_rxf`=1 with `cmdfifo_din`=0x3C. Pulse `cmdfifo_rd` → `cmdfifo_rxf`=0.
- Write 5 bytes back-to-back → `cmdfifo_txe` falls after the 4th push is stored. TX pops one byte, so `txe` re-rises. All frames are sent contiguously in order.
- Send 5 RX frames with no reads → 4 bytes are held and `rx_ovf_o`=1. Pulse `err_clr_i` → `rx_ovf_o`=0.
- Drive a 4-cycle low glitch → no push, FSM back in IDLE. Send a frame with stop=0 → `frame_err_o`=1, no push, line held low, next valid frame still received.
- Assert `reset_n_i` mid-TX-frame → `tx_o`=1 immediately, FIFOs empty, `cmdfifo_txe`=1.

Source files
------------

// File: rtl/serial_fifo_iface.sv
// serial_fifo_iface: UART front end with RX/TX FIFOs on the cmdfifo path.
// Define SERIAL_PARITY_EN for 8E1 framing with a sticky parity_err_o.
module serial_fifo_iface #(
   parameter int CLK_DIV = 868,
   parameter int RX_AW   = 4,
   parameter int TX_AW   = 4
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic       rx_i,
   output logic       tx_o,
   output logic       cmdfifo_rxf,
   output logic       cmdfifo_txe,
   input  logic       cmdfifo_rd,
   input  logic       cmdfifo_wr,
   output logic [7:0] cmdfifo_din,
   input  logic [7:0] cmdfifo_dout,
   output logic       tx_busy_o,
   input  logic       err_clr_i,
   output logic       rx_ovf_o,
`ifdef SERIAL_PARITY_EN
   output logic       parity_err_o,
`endif
   output logic       frame_err_o
);

   localparam int CW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_END = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);
   localparam int RX_DEPTH = 1 << RX_AW;
   localparam int TX_DEPTH = 1 << TX_AW;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef SERIAL_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP,
      RX_BREAK
   } rx_state_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
`ifdef SERIAL_PARITY_EN
      TX_PARITY,
`endif
      TX_STOP
   } tx_state_e;

   // ---------------- RX input synchronizer ----------------
   logic rx_meta_q, rx_sync_q, rx_prev_q;
   logic rx_fall;

   // Two-flop synchronizer plus one delay flop for edge detection
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign rx_fall = rx_prev_q & ~rx_sync_q;

   // ---------------- RX FIFO ----------------
   logic [7:0]     rx_mem_q [RX_DEPTH];
   logic [RX_AW:0] rx_wp_q, rx_rp_q;
   logic           rx_empty, rx_full;
   logic           rx_push_req, rx_push, rx_pop;
   logic [7:0]     rx_sr_q, rx_sr_d;

   assign rx_empty = (rx_wp_q == rx_rp_q);
   assign rx_full  = (rx_wp_q[RX_AW] != rx_rp_q[RX_AW]) &&
                     (rx_wp_q[RX_AW-1:0] == rx_rp_q[RX_AW-1:0]);
   assign rx_pop   = cmdfifo_rd & ~rx_empty;
   assign rx_push  = rx_push_req & (~rx_full | rx_pop);

   // RX FIFO pointers; a pop frees the slot a same-cycle push needs
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rx_wp_q <= '0;
         rx_rp_q <= '0;
      end else begin
         if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
         if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      end
   end

   // RX FIFO storage, contents are don't-care while empty
   always_ff @(posedge clk_i) begin
      if (rx_push) rx_mem_q[rx_wp_q[RX_AW-1:0]] <= rx_sr_q;
   end

   assign cmdfifo_rxf = ~rx_empty;
   assign cmdfifo_din = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q[RX_AW-1:0]];

   // ---------------- RX FSM ----------------
   rx_state_e     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic          rx_ferr_set;
   logic          rx_ovf_set;
`ifdef SERIAL_PARITY_EN
   logic          rx_pbad_q, rx_pbad_d;
   logic          rx_perr_set;
`endif

   // RX state, bit timer and shift register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sr_q    <= '0;
`ifdef SERIAL_PARITY_EN
         rx_pbad_q  <= 1'b0;
`endif
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sr_q    <= rx_sr_d;
`ifdef SERIAL_PARITY_EN
         rx_pbad_q  <= rx_pbad_d;
`endif
      end
   end

   // RX next state: half-bit start check, then mid-bit samples
   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q + CW'(1);
      rx_bit_d    = rx_bit_q;
      rx_sr_d     = rx_sr_q;
      rx_push_req = 1'b0;
      rx_ferr_set = 1'b0;
`ifdef SERIAL_PARITY_EN
      rx_pbad_d   = rx_pbad_q;
      rx_perr_set = 1'b0;
`endif
      unique case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_fall) begin
               rx_state_d = RX_START;
`ifdef SERIAL_PARITY_EN
               rx_pbad_d = 1'b0;
`endif
            end
         end
         RX_START: begin
            if (rx_cnt_q == CNT_HALF) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == CNT_END) begin
               rx_cnt_d = '0;
               rx_sr_d  = {rx_sync_q, rx_sr_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) begin
`ifdef SERIAL_PARITY_EN
                  rx_state_d = RX_PARITY;
`else
                  rx_state_d = RX_STOP;
`endif
               end
            end
         end
`ifdef SERIAL_PARITY_EN
         RX_PARITY: begin
            if (rx_cnt_q == CNT_END) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_STOP;
               if (rx_sync_q != ^rx_sr_q) begin
                  rx_pbad_d   = 1'b1;
                  rx_perr_set = 1'b1;
               end
            end
         end
`endif
         RX_STOP: begin
            if (rx_cnt_q == CNT_END) begin
               rx_cnt_d = '0;
               if (rx_sync_q) begin
                  rx_state_d = RX_IDLE;
`ifdef SERIAL_PARITY_EN
                  rx_push_req = ~rx_pbad_q;
`else
                  rx_push_req = 1'b1;
`endif
               end else begin
                  rx_ferr_set = 1'b1;
                  rx_state_d  = RX_BREAK;
               end
            end
         end
         RX_BREAK: begin
            rx_cnt_d = '0;
            if (rx_sync_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   assign rx_ovf_set = rx_push_req & ~rx_push;

   // ---------------- TX FIFO ----------------
   logic [7:0]     tx_mem_q [TX_DEPTH];
   logic [TX_AW:0] tx_wp_q, tx_rp_q;
   logic           tx_empty, tx_full;
   logic           tx_push, tx_pop;
   logic [7:0]     tx_head;

   assign tx_empty = (tx_wp_q == tx_rp_q);
   assign tx_full  = (tx_wp_q[TX_AW] != tx_rp_q[TX_AW]) &&
                     (tx_wp_q[TX_AW-1:0] == tx_rp_q[TX_AW-1:0]);
   assign tx_push  = cmdfifo_wr & (~tx_full | tx_pop);
   assign tx_head  = tx_mem_q[tx_rp_q[TX_AW-1:0]];

   // TX FIFO pointers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tx_wp_q <= '0;
         tx_rp_q <= '0;
      end else begin
         if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
         if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      end
   end

   // TX FIFO storage
   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem_q[tx_wp_q[TX_AW-1:0]] <= cmdfifo_dout;
   end

   assign cmdfifo_txe = ~tx_full;

   // ---------------- TX FSM ----------------
   tx_state_e     tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_sr_q, tx_sr_d;
   logic          tx_line_q, tx_line_d;
   logic          tx_act_q;
   logic          tx_pop_req;
`ifdef SERIAL_PARITY_EN
   logic          tx_par_q, tx_par_d;
`endif

   assign tx_pop = tx_pop_req & ~tx_empty;

   // TX state, timer, shifter and registered line driver
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sr_q    <= '0;
         tx_line_q  <= 1'b1;
         tx_act_q   <= 1'b0;
`ifdef SERIAL_PARITY_EN
         tx_par_q   <= 1'b0;
`endif
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sr_q    <= tx_sr_d;
         tx_line_q  <= tx_line_d;
         tx_act_q   <= (tx_state_q != TX_IDLE);
`ifdef SERIAL_PARITY_EN
         tx_par_q   <= tx_par_d;
`endif
      end
   end

   // TX next state; STOP chains straight into START when data waits
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + CW'(1);
      tx_bit_d   = tx_bit_q;
      tx_sr_d    = tx_sr_q;
      tx_pop_req = 1'b0;
      tx_line_d  = 1'b1;
`ifdef SERIAL_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      unique case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            if (!tx_empty) begin
               tx_pop_req = 1'b1;
               tx_sr_d    = tx_head;
               tx_state_d = TX_START;
`ifdef SERIAL_PARITY_EN
               tx_par_d = ^tx_head;
`endif
            end
         end
         TX_START: begin
            tx_line_d = 1'b0;
            if (tx_cnt_q == CNT_END) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
            end
         end
         TX_DATA: begin
            tx_line_d = tx_sr_q[0];
            if (tx_cnt_q == CNT_END) begin
               tx_cnt_d = '0;
               tx_sr_d  = {1'b0, tx_sr_q[7:1]};
               tx_bit_d = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) begin
`ifdef SERIAL_PARITY_EN
                  tx_state_d = TX_PARITY;
`else
                  tx_state_d = TX_STOP;
`endif
               end
            end
         end
`ifdef SERIAL_PARITY_EN
         TX_PARITY: begin
            tx_line_d = tx_par_q;
            if (tx_cnt_q == CNT_END) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_STOP;
            end
         end
`endif
         TX_STOP: begin
            if (tx_cnt_q == CNT_END) begin
               tx_cnt_d = '0;
               if (!tx_empty) begin
                  tx_pop_req = 1'b1;
                  tx_sr_d    = tx_head;
                  tx_state_d = TX_START;
`ifdef SERIAL_PARITY_EN
                  tx_par_d = ^tx_head;
`endif
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   assign tx_o      = tx_line_q;
   assign tx_busy_o = ~tx_empty | (tx_state_q != TX_IDLE) | tx_act_q;

   // ---------------- sticky error flags ----------------
   logic ovf_q, ferr_q;
`ifdef SERIAL_PARITY_EN
   logic perr_q;
`endif

   // Sticky flags; a set in the same cycle as a clear wins
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ovf_q  <= 1'b0;
         ferr_q <= 1'b0;
`ifdef SERIAL_PARITY_EN
         perr_q <= 1'b0;
`endif
      end else begin
         ovf_q  <= rx_ovf_set | (ovf_q & ~err_clr_i);
         ferr_q <= rx_ferr_set | (ferr_q & ~err_clr_i);
`ifdef SERIAL_PARITY_EN
         perr_q <= rx_perr_set | (perr_q & ~err_clr_i);
`endif
      end
   end

   assign rx_ovf_o    = ovf_q;
   assign frame_err_o = ferr_q;
`ifdef SERIAL_PARITY_EN
   assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_serial_fifo_iface.sv
// tb_serial_fifo_iface: directed bench for serial_fifo_iface.
// CLK_DIV=16, RX_AW=TX_AW=2; hand-computed frame and FIFO expectations.
module tb_serial_fifo_iface;

   localparam int DIV = 16;

   logic       clk_i = 1'b0;
   logic       reset_n_i;
   logic       rx_i;
   logic       tx_o;
   logic       cmdfifo_rxf;
   logic       cmdfifo_txe;
   logic       cmdfifo_rd;
   logic       cmdfifo_wr;
   logic [7:0] cmdfifo_din;
   logic [7:0] cmdfifo_dout;
   logic       tx_busy_o;
   logic       err_clr_i;
   logic       rx_ovf_o;
   logic       frame_err_o;
`ifdef SERIAL_PARITY_EN
   logic       parity_err_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   serial_fifo_iface #(
      .CLK_DIV(DIV),
      .RX_AW  (2),
      .TX_AW  (2)
   ) dut (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .rx_i        (rx_i),
      .tx_o        (tx_o),
      .cmdfifo_rxf (cmdfifo_rxf),
      .cmdfifo_txe (cmdfifo_txe),
      .cmdfifo_rd  (cmdfifo_rd),
      .cmdfifo_wr  (cmdfifo_wr),
      .cmdfifo_din (cmdfifo_din),
      .cmdfifo_dout(cmdfifo_dout),
      .tx_busy_o   (tx_busy_o),
      .err_clr_i   (err_clr_i),
      .rx_ovf_o    (rx_ovf_o),
`ifdef SERIAL_PARITY_EN
      .parity_err_o(parity_err_o),
`endif
      .frame_err_o (frame_err_o)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t",
                  tag, obs, exp, $time);
      end
   endtask

   // advance n rising edges, then settle 1 time unit
   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      cmdfifo_dout = b;
      cmdfifo_wr   = 1'b1;
      step(1);
      cmdfifo_wr   = 1'b0;
   endtask

   task automatic pop();
      cmdfifo_rd = 1'b1;
      step(1);
      cmdfifo_rd = 1'b0;
   endtask

   task automatic clr_err();
      err_clr_i = 1'b1;
      step(1);
      err_clr_i = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx_i = 1'b0;
      step(DIV);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         step(DIV);
      end
      rx_i = stop;
      step(DIV);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] frm;
      logic [7:0] txb [5];
      logic [7:0] rxb [5];

      txb[0] = 8'h11; txb[1] = 8'h82; txb[2] = 8'h5A;
      txb[3] = 8'hF0; txb[4] = 8'h0F;
      rxb[0] = 8'h01; rxb[1] = 8'h80; rxb[2] = 8'h55;
      rxb[3] = 8'hAA; rxb[4] = 8'hFE;

      reset_n_i    = 1'b0;
      rx_i         = 1'b1;
      cmdfifo_rd   = 1'b0;
      cmdfifo_wr   = 1'b0;
      cmdfifo_dout = 8'h00;
      err_clr_i    = 1'b0;
      step(3);
      check("rst_tx", tx_o, 1);
      check("rst_rxf", cmdfifo_rxf, 0);
      check("rst_txe", cmdfifo_txe, 1);
      check("rst_din", cmdfifo_din, 0);
      check("rst_busy", tx_busy_o, 0);
      check("rst_ovf", rx_ovf_o, 0);
      check("rst_ferr", frame_err_o, 0);
      reset_n_i = 1'b1;
      step(2);

      // single TX byte 0xA5: start, 1,0,1,0,0,1,0,1, stop
      push(8'hA5);
      check("tx_n0", tx_o, 1);
      step(1);
      check("tx_n1", tx_o, 1);
      step(1);
      check("tx_n2", tx_o, 0);
      frm = {1'b1, 8'hA5, 1'b0};
      step(8);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("tx_a5_bit%0d", i), tx_o, frm[i]);
         if (i < 9) step(DIV);
      end
      step(7);
      check("busy_n161", tx_busy_o, 1);
      step(1);
      check("busy_n162", tx_busy_o, 0);
      check("tx_idle", tx_o, 1);
      step(10);

      // single RX byte 0x3C
      send_frame(8'h3C, 1'b1);
      check("rx_rxf", cmdfifo_rxf, 1);
      check("rx_din", cmdfifo_din, 8'h3C);
      pop();
      check("rx_rxf_pop", cmdfifo_rxf, 0);
      check("rx_din_pop", cmdfifo_din, 0);

      // 5 back-to-back TX pushes, contiguous frames
      fork
         begin
            for (int i = 0; i < 5; i++) push(txb[i]);
            check("txe_full", cmdfifo_txe, 0);
            step(156);
            check("txe_n160", cmdfifo_txe, 0);
            step(1);
            check("txe_rise", cmdfifo_txe, 1);
         end
         begin
            int gap;
            logic [7:0] got;
            for (int f = 0; f < 5; f++) begin
               gap = 0;
               while (tx_o !== 1'b0 && gap < 400) begin
                  step(1);
                  gap++;
               end
               if (f > 0) check("tx_gap", gap, 8);
               else       check("tx_seen", tx_o, 0);
               step(8);
               check("tx_start", tx_o, 0);
               for (int b = 0; b < 8; b++) begin
                  step(DIV);
                  got[b] = tx_o;
               end
               check($sformatf("tx_byte%0d", f), got, txb[f]);
               step(DIV);
               check("tx_stop", tx_o, 1);
            end
         end
      join
      step(20);
      check("burst_busy", tx_busy_o, 0);

      // RX overflow: 5 frames into a 4-deep FIFO
      for (int i = 0; i < 5; i++) send_frame(rxb[i], 1'b1);
      check("ovf_set", rx_ovf_o, 1);
      check("ovf_ferr", frame_err_o, 0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovf_rxf%0d", i), cmdfifo_rxf, 1);
         check($sformatf("ovf_din%0d", i), cmdfifo_din, rxb[i]);
         pop();
      end
      check("ovf_empty", cmdfifo_rxf, 0);
      clr_err();
      check("ovf_clr", rx_ovf_o, 0);

      // 4-cycle start glitch is rejected
      rx_i = 1'b0;
      step(4);
      rx_i = 1'b1;
      step(30);
      check("glitch_rxf", cmdfifo_rxf, 0);
      check("glitch_ferr", frame_err_o, 0);

      // framing error with line held low, then recovery
      send_frame(8'h42, 1'b0);
      step(40);
      check("ferr_set", frame_err_o, 1);
      check("ferr_rxf", cmdfifo_rxf, 0);
      rx_i = 1'b1;
      step(20);
      send_frame(8'h96, 1'b1);
      check("ferr_next_rxf", cmdfifo_rxf, 1);
      check("ferr_next_din", cmdfifo_din, 8'h96);
      check("ferr_sticky", frame_err_o, 1);
      pop();
      clr_err();
      check("ferr_clr", frame_err_o, 0);

      // reset in the middle of a TX frame
      send_frame(8'h5A, 1'b1);
      check("mrst_rxf_pre", cmdfifo_rxf, 1);
      push(8'h00);
      push(8'hFF);
      push(8'h3C);
      step(50);
      check("mrst_tx_pre", tx_o, 0);
      reset_n_i = 1'b0;
      #1;
      check("mrst_tx", tx_o, 1);
      check("mrst_txe", cmdfifo_txe, 1);
      check("mrst_busy", tx_busy_o, 0);
      check("mrst_rxf", cmdfifo_rxf, 0);
      check("mrst_din", cmdfifo_din, 0);
      step(2);
      reset_n_i = 1'b1;
      step(40);
      check("mrst_tx_post", tx_o, 1);
      check("mrst_busy_post", tx_busy_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
